cpu7_exu_pipe_ctl: RTL and testbench
====================================

// Module: cpu7_exu_pipe_ctl
// PURPOSE
//  Execution-unit pipeline controller for the D/E/M/W integer path.
//  - Tracks valid, rd and wen per stage; drives the IRF write port.
//  - Resolves RAW hazards on rs1/rs2 by forwarding or by stalling D.
//  - Takes branch-redirect flushes.
//  - Sits between IFU decode outputs, the IRF read data and the ALU/LSU result buses.
// PARAMETERS
//  GRLEN    32  datapath width
//  RF_AW    5   register-address width; register 0 is hard zero
// PORTS
//  clk                  in   1      clock
//  resetn               in   1      asynchronous, active-low reset
//  ifu_exu_valid        in   1      D-stage instruction valid
//  ifu_exu_rs1_d        in   RF_AW  D source 1 address
//  ifu_exu_rs2_d        in   RF_AW  D source 2 address
//  ifu_exu_rs1_rd_d     in   1      D reads rs1
//  ifu_exu_rs2_rd_d     in   1      D reads rs2
//  ifu_exu_rf_wen_d     in   1      D writes rd
//  ifu_exu_rd_d         in   RF_AW  D destination
//  ifu_exu_ld_d         in   1      D is a load (result at M)
//  irf_ecl_rs1_data_d   in   GRLEN  IRF read data, source 1
//  irf_ecl_rs2_data_d   in   GRLEN  IRF read data, source 2
//  alu_ecl_res_e        in   GRLEN  ALU result, E stage
//  lsu_ecl_data_m       in   GRLEN  load data, M stage
//  exu_flush            in   1      redirect: kill D and E this cycle
//  ecl_stall_d          out  1      hold D; IFU re-presents same instruction
//  ecl_rs1_data_d       out  GRLEN  forwarded source 1 operand
//  ecl_rs2_data_d       out  GRLEN  forwarded source 2 operand
//  ecl_valid_e          out  1      E stage holds a live instruction
//  ecl_irf_wen_w        out  1      IRF write enable
//  ecl_irf_rd_w         out  RF_AW  IRF write address
//  ecl_irf_rd_data_w    out  GRLEN  IRF write data
// BEHAVIOUR
//  Reset:
//  - Async assert clears valid/wen/ld of E, M and W.
//  - All registered outputs go to 0.
//  - ecl_stall_d is 0 while resetn=0.
//  Stage advance:
//  - Every cycle, E<=D, M<=E, W<=M.
//  - D enters E only if ifu_exu_valid & !ecl_stall_d & !exu_flush; otherwise E gets a bubble (valid=0).
//  - exu_flush also clears valid_e in the same edge, so M receives a bubble.
//  - M and W are never flushed or stalled.
//  Write enable:
//  - wen_x = valid_x & rf_wen_x & (rd_x != 0).
//  - Register 0 is never written or forwarded.
//  Stage data:
//  - M data = ld_m ? lsu_ecl_data_m : registered alu_ecl_res_e.
//  - W data = registered M data.
//  - Write-back latency: 3 cycles from D acceptance to ecl_irf_wen_w.
//  Match:
//  - match_x(rs) = rs_rd_d & wen_x & (rd_x == rs).
//  - Youngest stage wins; priority E > M > W, then the IRF read.
//  - Forward sources: E from alu_ecl_res_e, M from M data, W from ecl_irf_rd_data_w.
//  - The W source covers the same-cycle IRF write (IRF has no write-through).
//  Load-use:
//  - match_e on a load (ld_e) asserts ecl_stall_d for 1 cycle.
//  - Next cycle the load is in M and is forwarded from M.
//  Stall/flush collision:
//  - exu_flush dominates; the stalled D is killed and ecl_stall_d is masked to 0.
//  - Simultaneous W write and D read of the same register: W forwarding supplies the data.
// CONFIGURATION
//  CPU7_EXU_BYPASS_EN defined:
//  - Forwarding network as above; the only stall is load-use.
//  CPU7_EXU_BYPASS_EN undefined:
//  - No forwarding muxes; operands come straight from the IRF.
//  - ecl_stall_d = OR of match_e, match_m and match_w over both sources.
//  - Stall holds until the producer has left W.
// TESTING
//  1. reset mid-run: valid writes in flight, resetn=0 -> wen_w=0 and rd_data_w=0 immediately; nothing written after release.
//  2. add r5 (ALU=0x11) then dependent rs1=r5 next cycle -> rs1_data_d=0x11 from E with no stall; no-bypass build stalls 3 cycles.
//  3. load r7 (mem=0xCAFE) then use r7 -> exactly 1 stall cycle, then rs2_data_d=0xCAFE from M.
//  4. r5 written in W while D reads r5, IRF returns stale 0x0 -> rs1_data_d = W data.
//  5. write r0 with 0x55, then read r0 -> ecl_irf_wen_w=0 and operand=0.
//  6. exu_flush during a load-use stall -> stall drops; E and M receive bubbles; killed instructions never assert wen_w.

Source files
------------

// File: rtl/cpu7_exu_pipe_ctl.sv
// cpu7_exu_pipe_ctl
//   Pipeline control for the D/E/M/W integer path: per-stage valid/rd/wen
//   tracking, IRF write-port drive, RAW hazard resolution and redirect flush.
//   Optional macro: CPU7_EXU_BYPASS_EN
//     defined   -> full E/M/W forwarding network, only load-use stalls D.
//     undefined -> operands straight from the IRF, D stalls on any RAW
//                  match until the producer has left W.
module cpu7_exu_pipe_ctl #(
  parameter int GRLEN = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ifu_exu_valid,
  input  logic [RF_AW-1:0] ifu_exu_rs1_d,
  input  logic [RF_AW-1:0] ifu_exu_rs2_d,
  input  logic             ifu_exu_rs1_rd_d,
  input  logic             ifu_exu_rs2_rd_d,
  input  logic             ifu_exu_rf_wen_d,
  input  logic [RF_AW-1:0] ifu_exu_rd_d,
  input  logic             ifu_exu_ld_d,
  input  logic [GRLEN-1:0] irf_ecl_rs1_data_d,
  input  logic [GRLEN-1:0] irf_ecl_rs2_data_d,
  input  logic [GRLEN-1:0] alu_ecl_res_e,
  input  logic [GRLEN-1:0] lsu_ecl_data_m,
  input  logic             exu_flush,
  output logic             ecl_stall_d,
  output logic [GRLEN-1:0] ecl_rs1_data_d,
  output logic [GRLEN-1:0] ecl_rs2_data_d,
  output logic             ecl_valid_e,
  output logic             ecl_irf_wen_w,
  output logic [RF_AW-1:0] ecl_irf_rd_w,
  output logic [GRLEN-1:0] ecl_irf_rd_data_w
);

  // E stage control
  logic             r_valid_e;
  logic             r_rf_wen_e;
  logic             r_ld_e;
  logic [RF_AW-1:0] r_rd_e;

  // M stage control plus the ALU result captured when leaving E
  logic             r_valid_m;
  logic             r_rf_wen_m;
  logic             r_ld_m;
  logic [RF_AW-1:0] r_rd_m;
  logic [GRLEN-1:0] r_alu_m;

  // W stage: these registers are the IRF write port
  logic             r_wen_w;
  logic [RF_AW-1:0] r_rd_w;
  logic [GRLEN-1:0] r_data_w;

  logic             w_wen_e;
  logic             w_wen_m;
  logic [GRLEN-1:0] w_data_m;
  logic             w_m1_e, w_m1_m, w_m1_w;
  logic             w_m2_e, w_m2_m, w_m2_w;
  logic             w_stall_raw;
  logic             w_d_accept;
  logic [GRLEN-1:0] w_rs1_data;
  logic [GRLEN-1:0] w_rs2_data;

  // A stage only writes when live, enabled and not targeting hard-zero r0;
  // this also keeps r0 out of every forwarding match below.
  assign w_wen_e  = r_valid_e & r_rf_wen_e & (r_rd_e != '0);
  assign w_wen_m  = r_valid_m & r_rf_wen_m & (r_rd_m != '0);
  assign w_data_m = r_ld_m ? lsu_ecl_data_m : r_alu_m;

  assign w_m1_e = ifu_exu_rs1_rd_d & w_wen_e & (r_rd_e == ifu_exu_rs1_d);
  assign w_m1_m = ifu_exu_rs1_rd_d & w_wen_m & (r_rd_m == ifu_exu_rs1_d);
  assign w_m1_w = ifu_exu_rs1_rd_d & r_wen_w & (r_rd_w == ifu_exu_rs1_d);
  assign w_m2_e = ifu_exu_rs2_rd_d & w_wen_e & (r_rd_e == ifu_exu_rs2_d);
  assign w_m2_m = ifu_exu_rs2_rd_d & w_wen_m & (r_rd_m == ifu_exu_rs2_d);
  assign w_m2_w = ifu_exu_rs2_rd_d & r_wen_w & (r_rd_w == ifu_exu_rs2_d);

`ifdef CPU7_EXU_BYPASS_EN
  // Load data only exists from M onward, so a load in E cannot be forwarded.
  assign w_stall_raw = r_ld_e & (w_m1_e | w_m2_e);
`else
  // Without forwarding D waits until no in-flight producer matches.
  assign w_stall_raw = w_m1_e | w_m1_m | w_m1_w | w_m2_e | w_m2_m | w_m2_w;
`endif

  // A redirect kills D anyway, so holding it would only waste the refetch.
  assign ecl_stall_d = w_stall_raw & ~exu_flush & resetn;
  assign w_d_accept  = ifu_exu_valid & ~ecl_stall_d & ~exu_flush;

  // Operand select: youngest producer wins, IRF read data is the fallback.
  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    w_rs1_data = irf_ecl_rs1_data_d;
    w_rs2_data = irf_ecl_rs2_data_d;
`ifdef CPU7_EXU_BYPASS_EN
    if (w_m1_e)      w_rs1_data = alu_ecl_res_e;
    else if (w_m1_m) w_rs1_data = w_data_m;
    else if (w_m1_w) w_rs1_data = r_data_w;
    if (w_m2_e)      w_rs2_data = alu_ecl_res_e;
    else if (w_m2_m) w_rs2_data = w_data_m;
    else if (w_m2_w) w_rs2_data = r_data_w;
`endif
  end

  assign ecl_rs1_data_d = w_rs1_data;
  assign ecl_rs2_data_d = w_rs2_data;

  // D -> E: a rejected, stalled or flushed D leaves a bubble in E.
  // NOTE: non-blocking assignments so every stage samples the pre-edge value of its predecessor.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid_e  <= 1'b0;
      r_rf_wen_e <= 1'b0;
      r_ld_e     <= 1'b0;
      r_rd_e     <= '0;
    end else begin
      r_valid_e  <= w_d_accept;
      r_rf_wen_e <= w_d_accept & ifu_exu_rf_wen_d;
      r_ld_e     <= w_d_accept & ifu_exu_ld_d;
      r_rd_e     <= ifu_exu_rd_d;
    end
  end

  // E -> M -> W: a flush kills the E occupant, so M receives a bubble.
  // NOTE: data registers are reset too because they drive the IRF write port directly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid_m  <= 1'b0;
      r_rf_wen_m <= 1'b0;
      r_ld_m     <= 1'b0;
      r_rd_m     <= '0;
      r_alu_m    <= '0;
      r_wen_w    <= 1'b0;
      r_rd_w     <= '0;
      r_data_w   <= '0;
    end else begin
      r_valid_m  <= r_valid_e & ~exu_flush;
      r_rf_wen_m <= r_rf_wen_e;
      r_ld_m     <= r_ld_e;
      r_rd_m     <= r_rd_e;
      r_alu_m    <= alu_ecl_res_e;
      r_wen_w    <= w_wen_m;
      r_rd_w     <= r_rd_m;
      r_data_w   <= w_data_m;
    end
  end

  assign ecl_valid_e       = r_valid_e;
  assign ecl_irf_wen_w     = r_wen_w;
  assign ecl_irf_rd_w      = r_rd_w;
  assign ecl_irf_rd_data_w = r_data_w;

endmodule

// File: tb/tb_cpu7_exu_pipe_ctl.sv
// tb_cpu7_exu_pipe_ctl
//   Directed vectors against cpu7_exu_pipe_ctl. Issued instructions push
//   their expected operands and expected IRF write into queues; a monitor
//   on the falling edge pops and compares whenever D is accepted or the
//   write port fires. Expectations cover both CPU7_EXU_BYPASS_EN builds.
`timescale 1ns/1ps
module tb_cpu7_exu_pipe_ctl;

`ifdef CPU7_EXU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        ifu_exu_valid;
  logic [4:0]  ifu_exu_rs1_d;
  logic [4:0]  ifu_exu_rs2_d;
  logic        ifu_exu_rs1_rd_d;
  logic        ifu_exu_rs2_rd_d;
  logic        ifu_exu_rf_wen_d;
  logic [4:0]  ifu_exu_rd_d;
  logic        ifu_exu_ld_d;
  logic [31:0] irf_ecl_rs1_data_d;
  logic [31:0] irf_ecl_rs2_data_d;
  logic [31:0] alu_ecl_res_e;
  logic [31:0] lsu_ecl_data_m;
  logic        exu_flush;
  logic        ecl_stall_d;
  logic [31:0] ecl_rs1_data_d;
  logic [31:0] ecl_rs2_data_d;
  logic        ecl_valid_e;
  logic        ecl_irf_wen_w;
  logic [4:0]  ecl_irf_rd_w;
  logic [31:0] ecl_irf_rd_data_w;

  cpu7_exu_pipe_ctl #(.GRLEN(32), .RF_AW(5)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .ifu_exu_valid      (ifu_exu_valid),
    .ifu_exu_rs1_d      (ifu_exu_rs1_d),
    .ifu_exu_rs2_d      (ifu_exu_rs2_d),
    .ifu_exu_rs1_rd_d   (ifu_exu_rs1_rd_d),
    .ifu_exu_rs2_rd_d   (ifu_exu_rs2_rd_d),
    .ifu_exu_rf_wen_d   (ifu_exu_rf_wen_d),
    .ifu_exu_rd_d       (ifu_exu_rd_d),
    .ifu_exu_ld_d       (ifu_exu_ld_d),
    .irf_ecl_rs1_data_d (irf_ecl_rs1_data_d),
    .irf_ecl_rs2_data_d (irf_ecl_rs2_data_d),
    .alu_ecl_res_e      (alu_ecl_res_e),
    .lsu_ecl_data_m     (lsu_ecl_data_m),
    .exu_flush          (exu_flush),
    .ecl_stall_d        (ecl_stall_d),
    .ecl_rs1_data_d     (ecl_rs1_data_d),
    .ecl_rs2_data_d     (ecl_rs2_data_d),
    .ecl_valid_e        (ecl_valid_e),
    .ecl_irf_wen_w      (ecl_irf_wen_w),
    .ecl_irf_rd_w       (ecl_irf_rd_w),
    .ecl_irf_rd_data_w  (ecl_irf_rd_data_w)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    string       name;
  } wb_t;

  typedef struct {
    logic        c1;
    logic [31:0] e1;
    logic        c2;
    logic [31:0] e2;
    string       name;
  } op_t;

  wb_t wb_q[$];
  op_t op_q[$];
  int  checks = 0;
  int  errors = 0;

  // Environment: IRF array, ALU/LSU result timing for the accepted instruction
  logic [31:0] irf [32];
  logic [31:0] alu_d, mem_d;
  logic [31:0] tb_alu_e, tb_mem_e, tb_mem_m;
  logic        tb_acc_n, tb_wen_n;
  logic [4:0]  tb_rd_n;
  logic [31:0] tb_data_n;

  assign irf_ecl_rs1_data_d = irf[ifu_exu_rs1_d];
  assign irf_ecl_rs2_data_d = irf[ifu_exu_rs2_d];
  assign alu_ecl_res_e      = tb_alu_e;
  assign lsu_ecl_data_m     = tb_mem_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Sample DUT handshakes mid-cycle, apply them on the next rising edge
  always @(negedge clk) begin
    tb_acc_n  <= ifu_exu_valid & ~ecl_stall_d & ~exu_flush;
    tb_wen_n  <= ecl_irf_wen_w;
    tb_rd_n   <= ecl_irf_rd_w;
    tb_data_n <= ecl_irf_rd_data_w;
  end

  // Result buses follow the accepted instruction; IRF takes the W write
  always @(posedge clk) begin
    tb_alu_e <= tb_acc_n ? alu_d : 32'h0;
    tb_mem_e <= tb_acc_n ? mem_d : 32'h0;
    tb_mem_m <= tb_mem_e;
    if (tb_wen_n && resetn) irf[tb_rd_n] <= tb_data_n;
  end

  // Monitor: compare write-port activity and accepted operands to the queues
  always @(negedge clk) begin
    if (resetn) begin
      if (ecl_irf_wen_w) begin
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: actual rd=%0d data=0x%0h required no write",
                   ecl_irf_rd_w, ecl_irf_rd_data_w);
        end else begin
          wb_t w;
          w = wb_q.pop_front();
          check({w.name, "_wb_rd"}, 32'(ecl_irf_rd_w), 32'(w.rd));
          check({w.name, "_wb_data"}, ecl_irf_rd_data_w, w.data);
        end
      end
      if (ifu_exu_valid && !ecl_stall_d && !exu_flush) begin
        if (op_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: actual accept required none");
        end else begin
          op_t o;
          o = op_q.pop_front();
          if (o.c1) check({o.name, "_rs1"}, ecl_rs1_data_d, o.e1);
          if (o.c2) check({o.name, "_rs2"}, ecl_rs2_data_d, o.e2);
        end
      end
    end
  end

  task automatic d_idle();
    ifu_exu_valid    = 1'b0;
    ifu_exu_rs1_d    = 5'd0;
    ifu_exu_rs2_d    = 5'd0;
    ifu_exu_rs1_rd_d = 1'b0;
    ifu_exu_rs2_rd_d = 1'b0;
    ifu_exu_rf_wen_d = 1'b0;
    ifu_exu_rd_d     = 5'd0;
    ifu_exu_ld_d     = 1'b0;
    alu_d            = 32'h0;
    mem_d            = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one instruction in D, hold it through stalls, check stall count
  task automatic issue(input string name,
                       input logic [4:0] rs1, input logic r1,
                       input logic [4:0] rs2, input logic r2,
                       input logic wen, input logic [4:0] rd, input logic ld,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic c1, input logic [31:0] e1,
                       input logic c2, input logic [31:0] e2,
                       input int exp_stall,
                       input logic exp_wb, input logic [31:0] wb_data);
    op_t  o;
    wb_t  w;
    int   stalls = 0;
    logic acc = 1'b0;
    ifu_exu_valid    = 1'b1;
    ifu_exu_rs1_d    = rs1;
    ifu_exu_rs1_rd_d = r1;
    ifu_exu_rs2_d    = rs2;
    ifu_exu_rs2_rd_d = r2;
    ifu_exu_rf_wen_d = wen;
    ifu_exu_rd_d     = rd;
    ifu_exu_ld_d     = ld;
    alu_d            = alu;
    mem_d            = mem;
    o.c1 = c1; o.e1 = e1; o.c2 = c2; o.e2 = e2; o.name = name;
    op_q.push_back(o);
    if (exp_wb) begin
      w.rd = rd; w.data = wb_data; w.name = name;
      wb_q.push_back(w);
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (!ecl_stall_d) begin
        acc = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual still stalled required accept", name);
    end else begin
      @(posedge clk);
      #1;
    end
    check({name, "_stalls"}, 32'(stalls), 32'(exp_stall));
    d_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual time limit reached required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) irf[i] = 32'h0;
    resetn    = 1'b1;
    exu_flush = 1'b0;
    d_idle();
    #2 resetn = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wen_w",  32'(ecl_irf_wen_w), 32'h0);
    check("rst_rd_w",   32'(ecl_irf_rd_w), 32'h0);
    check("rst_data_w", ecl_irf_rd_data_w, 32'h0);
    check("rst_valid_e", 32'(ecl_valid_e), 32'h0);
    check("rst_stall",  32'(ecl_stall_d), 32'h0);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Dependent ALU op right behind its producer
    issue("add_r5", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h11, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'h11);
    issue("use_r5", 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
          1'b1, 32'h11, 1'b1, 32'h0, BYP ? 0 : 3, 1'b0, 32'h0);
    idle(4);

    // Load-use: load data must come from the LSU bus, not the ALU address
    issue("ld_r7", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 32'hDEAD0000, 32'hCAFE,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'hCAFE);
    issue("use_r7", 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
          1'b0, 32'h0, 1'b1, 32'hCAFE, BYP ? 1 : 3, 1'b0, 32'h0);
    idle(4);

    // Three producers of r3 in flight: the youngest value must win
    issue("w3a", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 32'hA1, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'hA1);
    issue("w3b", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 32'hA2, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'hA2);
    issue("w3c", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 32'hA3, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'hA3);
    issue("use_r3", 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
          1'b1, 32'hA3, 1'b1, 32'hA3, BYP ? 0 : 3, 1'b0, 32'h0);
    idle(4);

    // r9 being written in W while D reads it; IRF still holds stale 0
    issue("w9", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 32'h99, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'h99);
    issue("nop1", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    issue("nop2", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    issue("use_r9", 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
          1'b1, 32'h99, 1'b1, 32'h11, BYP ? 0 : 1, 1'b0, 32'h0);
    idle(4);

    // Address match without a read request is not a hazard
    issue("w10", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 32'h1010, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'h1010);
    issue("noread_r10", 5'd10, 1'b0, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    idle(4);

    // r0 write is dropped and r0 reads stay zero with no stall
    issue("w_r0", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h55, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    issue("use_r0", 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
          1'b1, 32'h0, 1'b1, 32'h0, 0, 1'b0, 32'h0);
    idle(4);

    // Flush arriving during a load-use stall kills both the load and its user
    begin
      op_t o;
      ifu_exu_valid    = 1'b1;
      ifu_exu_rf_wen_d = 1'b1;
      ifu_exu_rd_d     = 5'd7;
      ifu_exu_ld_d     = 1'b1;
      alu_d            = 32'h0;
      mem_d            = 32'hBEEF;
      o.c1 = 1'b0; o.e1 = 32'h0; o.c2 = 1'b0; o.e2 = 32'h0; o.name = "flush_ld";
      op_q.push_back(o);
    end
    @(negedge clk);
    check("flush_ld_stall", 32'(ecl_stall_d), 32'h0);
    @(posedge clk);
    #1;
    d_idle();
    ifu_exu_valid    = 1'b1;
    ifu_exu_rs1_d    = 5'd7;
    ifu_exu_rs1_rd_d = 1'b1;
    ifu_exu_rf_wen_d = 1'b1;
    ifu_exu_rd_d     = 5'd8;
    alu_d            = 32'h88;
    @(negedge clk);
    check("flush_pre_stall", 32'(ecl_stall_d), 32'h1);
    check("flush_pre_valid_e", 32'(ecl_valid_e), 32'h1);
    #1 exu_flush = 1'b1;
    #1 check("flush_stall_masked", 32'(ecl_stall_d), 32'h0);
    @(posedge clk);
    #1;
    exu_flush = 1'b0;
    d_idle();
    check("flush_e_bubble", 32'(ecl_valid_e), 32'h0);
    idle(5);

    // Reset with writes in flight: port drops at once, nothing lands later
    issue("rst_a", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, 32'h111, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'h111);
    issue("rst_b", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0, 32'h222, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 32'h222);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    ifu_exu_valid    = 1'b1;
    ifu_exu_rs1_d    = 5'd12;
    ifu_exu_rs1_rd_d = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("midrst_wen_w",   32'(ecl_irf_wen_w), 32'h0);
    check("midrst_rd_w",    32'(ecl_irf_rd_w), 32'h0);
    check("midrst_data_w",  ecl_irf_rd_data_w, 32'h0);
    check("midrst_valid_e", 32'(ecl_valid_e), 32'h0);
    check("midrst_stall",   32'(ecl_stall_d), 32'h0);
    d_idle();
    wb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
    idle(6);

    check("wb_queue_empty", 32'(wb_q.size()), 32'h0);
    check("op_queue_empty", 32'(op_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
